sys_input_port: RTL and testbench

//  Input-side counterpart of the per-register output-enable logic: accepts words from an

---
 rtl/sys_input_port_pkg.sv | 23 ++
 rtl/sys_input_port_fifo.sv | 66 ++++++
 rtl/sys_input_port.sv | 52 +++++
 tb/tb_sys_input_port.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/sys_input_port_pkg.sv
// Shared constants for the processor I/O port logic: register index space,
// input register mapping and load-source codes used by the output-enable decoders.
package sys_input_port_pkg;

    localparam int REG_IDX_W  = 5;
    localparam int DATA_W_DEF = 8;
    localparam logic [REG_IDX_W-1:0] IN_REG_IDX = 5'd5;

    typedef enum logic [1:0] {
        LD_NONE = 2'b00,
        LD_ALU  = 2'b01,
        LD_MEM  = 2'b10,
        LD_IN   = 2'b11
    } ld_code_e;

    function automatic logic reg_match(
        input logic [REG_IDX_W-1:0] idx,
        input logic [REG_IDX_W-1:0] target
    );
        return idx == target;
    endfunction

endpackage

// File: rtl/sys_input_port_fifo.sv
// First-word-fall-through FIFO: head word is visible on data_o while non-empty,
// zero when empty so nothing undefined reaches the register file.
module sys_input_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] data_o,
    output logic [CNT_W-1:0]  level_o,
    output logic              full_o,
    output logic              empty_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push_i && !pop_i) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_i && pop_i) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; empty_o masks stale contents on the output.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign level_o = count_q;
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/sys_input_port.sv
// Input port: buffers producer words and hands them to instructions reading IN_REG,
// stalling the pipeline when such a read finds the buffer empty.
module sys_input_port
    import sys_input_port_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 4,
    parameter logic [REG_IDX_W-1:0] IN_REG = IN_REG_IDX,
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic                 system1000,
    input  logic                 system1000_rstn,
    input  logic [DATA_W-1:0]    in_data_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [REG_IDX_W-1:0] rd_reg_i,
    input  logic                 rd_en_i,
    output logic [DATA_W-1:0]    rd_data_o,
    output logic                 hit_o,
    output logic                 stall_o,
    output logic [LVL_W-1:0]     level_o
);

    logic sel;
    logic push;
    logic full;
    logic empty;

    assign sel = rd_en_i && reg_match(rd_reg_i, IN_REG);

    // Ready depends on registered occupancy only, never on a same-cycle pop.
    assign in_ready_o = system1000_rstn && !full;
    assign push       = in_valid_i && in_ready_o;
    assign hit_o      = sel && !empty;
    assign stall_o    = sel && empty;

    sys_input_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk_i   (system1000),
        .rst_ni  (system1000_rstn),
        .push_i  (push),
        .data_i  (in_data_i),
        .pop_i   (hit_o),
        .data_o  (rd_data_o),
        .level_o (level_o),
        .full_o  (full),
        .empty_o (empty)
    );

endmodule

// File: tb/tb_sys_input_port.sv
// Directed bench for sys_input_port: handshake, FIFO order, stall, reset and wrap.
module tb_sys_input_port;

    logic       clk = 1'b0;
    logic       rstn;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] rd_reg;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       hit;
    logic       stall;
    logic [2:0] level;

    int total  = 0;
    int passed = 0;

    logic [7:0] q[$];
    logic [7:0] exp_rd [4];

    sys_input_port #(
        .DATA_W (8),
        .DEPTH  (4),
        .IN_REG (5'd5)
    ) dut (
        .system1000      (clk),
        .system1000_rstn (rstn),
        .in_data_i       (in_data),
        .in_valid_i      (in_valid),
        .in_ready_o      (in_ready),
        .rd_reg_i        (rd_reg),
        .rd_en_i         (rd_en),
        .rd_data_o       (rd_data),
        .hit_o           (hit),
        .stall_o         (stall),
        .level_o         (level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn     = 1'b1;
        in_data  = 8'h99;
        in_valid = 1'b1;
        rd_reg   = 5'd5;
        rd_en    = 1'b1;
        #2 rstn  = 1'b0;
        #1;
        // reset state
        chk("rst_ready", in_ready, 0);
        chk("rst_level", level, 0);
        chk("rst_rdata", rd_data, 0);
        chk("rst_hit", hit, 0);
        chk("rst_stall", stall, 1);
        tick();
        chk("rst_level2", level, 0);
        in_valid = 1'b0;
        rd_en    = 1'b0;
        tick();
        rstn = 1'b1;
        #1;
        chk("rel_ready", in_ready, 1);
        chk("rel_level", level, 0);
        tick();

        // fill back-to-back
        for (int i = 0; i < 4; i++) begin
            in_data  = 8'(8'h11 * (i + 1));
            in_valid = 1'b1;
            #1;
            chk("fill_ready", in_ready, 1);
            chk("fill_level", level, i);
            tick();
        end
        in_data = 8'h55;
        #1;
        chk("full_ready", in_ready, 0);
        chk("full_level", level, 4);
        tick();
        chk("held_level", level, 4);
        rd_en  = 1'b1;
        rd_reg = 5'd5;
        #1;
        chk("fullpop_hit", hit, 1);
        chk("fullpop_data", rd_data, 8'h11);
        chk("fullpop_ready", in_ready, 0);
        tick();
        rd_en = 1'b0;
        #1;
        chk("afterpop_level", level, 3);
        chk("afterpop_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;

        // drain in order
        exp_rd[0] = 8'h22;
        exp_rd[1] = 8'h33;
        exp_rd[2] = 8'h44;
        exp_rd[3] = 8'h55;
        rd_en = 1'b1;
        for (int j = 0; j < 4; j++) begin
            #1;
            chk("drain_hit", hit, 1);
            chk("drain_data", rd_data, exp_rd[j]);
            chk("drain_level", level, 4 - j);
            tick();
        end
        #1;
        chk("drained_level", level, 0);

        // empty read stalls, no bypass
        chk("empty_stall", stall, 1);
        chk("empty_hit", hit, 0);
        chk("empty_rdata", rd_data, 0);
        tick();
        in_valid = 1'b1;
        in_data  = 8'hA5;
        #1;
        chk("nobypass_stall", stall, 1);
        chk("nobypass_hit", hit, 0);
        tick();
        in_valid = 1'b0;
        #1;
        chk("lat_stall", stall, 0);
        chk("lat_hit", hit, 1);
        chk("lat_data", rd_data, 8'hA5);
        tick();
        rd_en = 1'b0;
        #1;
        chk("lat_level", level, 0);

        // simultaneous push and pop
        in_valid = 1'b1;
        in_data  = 8'h77;
        tick();
        in_data = 8'h88;
        tick();
        in_data = 8'h66;
        rd_en   = 1'b1;
        #1;
        chk("pp_level_pre", level, 2);
        chk("pp_hit", hit, 1);
        chk("pp_data", rd_data, 8'h77);
        tick();
        in_valid = 1'b0;
        rd_reg   = 5'd4;
        #1;
        chk("pp_level", level, 2);
        chk("other_hit", hit, 0);
        chk("other_stall", stall, 0);
        chk("other_head", rd_data, 8'h88);
        tick();
        rd_reg = 5'd5;
        rd_en  = 1'b0;
        #1;
        chk("other_level", level, 2);
        chk("noen_hit", hit, 0);
        rd_en = 1'b1;
        #1;
        chk("pp_order1", rd_data, 8'h88);
        tick();
        chk("pp_order2", rd_data, 8'h66);
        tick();
        rd_en = 1'b0;

        // reset mid-stream
        in_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in_data = 8'(i);
            tick();
        end
        in_valid = 1'b0;
        #1;
        chk("pre_rst_level", level, 3);
        in_valid = 1'b1;
        in_data  = 8'hEE;
        rstn     = 1'b0;
        #1;
        chk("mid_rst_level", level, 0);
        chk("mid_rst_rdata", rd_data, 0);
        chk("mid_rst_ready", in_ready, 0);
        tick();
        in_valid = 1'b0;
        rstn     = 1'b1;
        #1;
        chk("mid_rel_level", level, 0);
        chk("mid_rel_ready", in_ready, 1);

        // scoreboard run across pointer wrap
        q.delete();
        rd_reg = 5'd5;
        for (int i = 0; i < 40; i++) begin
            in_valid = (i % 3) != 2;
            rd_en    = (i % 4) != 1;
            in_data  = 8'(i * 7 + 3);
            #1;
            chk("sb_level", level, q.size());
            chk("sb_ready", in_ready, q.size() < 4);
            chk("sb_hit", hit, rd_en && q.size() > 0);
            chk("sb_stall", stall, rd_en && q.size() == 0);
            if (rd_en && q.size() > 0) begin
                chk("sb_data", rd_data, q.pop_front());
            end
            if (in_valid && q.size() < 4) begin
                q.push_back(in_data);
            end
            tick();
        end
        in_valid = 1'b0;
        rd_en    = 1'b0;
        #1;
        chk("sb_final_level", level, q.size());

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
